cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, byte-queue depth (power of two, at least 4).
REQ-002 SHALL have port CLK_I  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port nRST_I  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port I_ADDR_O  output  14  ICode ROM byte address.
REQ-005 SHALL have port I_DAT_I  input  8  ROM data; valid one cycle after the address it answers.
REQ-006 SHALL have port REDIR_I  input  1  redirect strobe (jump/call/return taken).
REQ-007 SHALL have port REDIR_ADDR_I  input  14  redirect target address.
REQ-008 SHALL have port INS_VALID_O  output  1  assembled instruction available.
REQ-009 SHALL have port INS_READY_I  input  1  decode stage accepts the instruction.
REQ-010 SHALL have port INS_ICODE_O  output  8  opcode byte.
REQ-011 SHALL have port INS_VALC_O  output  8  second byte (immediate or address low); 0 for 1-byte instructions.
REQ-012 SHALL have port INS_VALP_O  output  14  {third byte[5:0], second byte} for 3-byte instructions; 0 otherwise.
REQ-013 SHALL have port INS_LEN_O  output  2  instruction length 1..3.
REQ-014 SHALL have port INS_PC_O  output  14  address of the opcode byte.
REQ-015 SHALL have port INS_NPC_O  output  14  INS_PC_O + INS_LEN_O, mod 2^14.

Function
REQ-016 SHALL keep a fetch PC; each cycle it issues I_ADDR_O = fetch PC only if (queued bytes + in-flight bytes) < QDEPTH, then increments fetch PC mod 2^14 (3FFF -> 0000).
REQ-017 SHALL hold I_ADDR_O at its last value when not issuing, and SHALL ignore I_DAT_I for non-issued cycles.
REQ-018 SHALL push I_DAT_I, tagged with its address, into the byte queue one cycle after issue; at most one in-flight byte per cycle.
REQ-019 SHALL decode length from the head byte: 01xxxxx0 -> 3; 00xxx1x0 -> 2; all other bytes -> 1.
REQ-020 SHALL assert INS_VALID_O combinationally when queued bytes >= head length; all INS_* outputs are 0 when INS_VALID_O is 0.
REQ-021 SHALL pop exactly INS_LEN_O bytes on a cycle with INS_VALID_O and INS_READY_I high; a push may occur in the same cycle.
REQ-022 SHALL hold INS_* stable while INS_VALID_O is high and INS_READY_I is low.
REQ-023 SHALL, on REDIR_I high: empty the queue, discard the in-flight byte, set fetch PC = REDIR_ADDR_I, and drive INS_VALID_O low that cycle; REDIR_I overrides a simultaneous handshake, and the accepted instruction is lost.
REQ-024 SHALL issue REDIR_ADDR_I on the cycle after redirect; first instruction valid no earlier than 2 cycles after redirect (1-byte) or 4 cycles after (3-byte).
REQ-025 SHALL treat a 2/3-byte instruction spanning 3FFF->0000 as contiguous (bytes from 3FFF, 0000, 0001).
REQ-026 SHALL sustain one 1-byte instruction per cycle in steady state with INS_READY_I held high.
REQ-027 SHALL never overflow the queue; full queue stalls issue only, never drops bytes.

Reset
REQ-028 SHALL, while nRST_I is low, asynchronously clear: fetch PC = 0, I_ADDR_O = 0, queue empty, no in-flight byte, INS_VALID_O = 0, all INS_* = 0.
REQ-029 SHALL issue address 0000 on the first rising edge after nRST_I deasserts; reset mid-operation discards all queued and in-flight bytes.

Verification
REQ-030 SHALL pass: reset, ROM[0..3]=C1,C2,C3,C4, READY=1 -> ICODE C1,C2,C3,C4 on consecutive cycles, LEN=1, PC 0000..0003.
REQ-031 SHALL pass: ROM[0..2]=06,5A,44, READY=1 -> first ICODE 06, VALC 5A, LEN 2, NPC 0002; then ICODE 44, LEN 3 once bytes 3,4 arrive.
REQ-032 SHALL pass: ROM[10..12]=44,34,12 at PC 0010 -> ICODE 44, VALP 1234, LEN 3, NPC 0013.
REQ-033 SHALL pass: READY=0 for 10 cycles after reset -> INS_* constant, I_ADDR_O stops after QDEPTH issues, no byte lost after READY=1.
REQ-034 SHALL pass: REDIR_I with REDIR_ADDR_I=2000 and a simultaneous handshake -> no further instruction from old stream; next INS_PC_O=2000.
REQ-035 SHALL pass: redirect to 3FFF, ROM[3FFF]=44, ROM[0000]=CD, ROM[0001]=2B -> ICODE 44, VALP 2BCD, NPC 0002; nRST_I pulsed low mid-run -> INS_VALID_O=0 immediately.

Source files
------------

// File: rtl/cpu_fetch_if.sv
// cpu_fetch_if -- bus bundle between the instruction fetch unit and its
// neighbours (ICode ROM, redirect source, decode stage).
//   I_ADDR_O / I_DAT_I        : ROM byte address out, ROM data back one cycle later
//   REDIR_I / REDIR_ADDR_I    : taken jump/call/return strobe and its target
//   INS_VALID_O / INS_READY_I : valid/ready handshake toward decode
//   INS_ICODE_O .. INS_NPC_O  : fields of the assembled instruction
// The master modport is the fetch unit; the slave modport is its environment.
interface cpu_fetch_if;
  logic [13:0] I_ADDR_O;
  logic [7:0]  I_DAT_I;
  logic        REDIR_I;
  logic [13:0] REDIR_ADDR_I;
  logic        INS_VALID_O;
  logic        INS_READY_I;
  logic [7:0]  INS_ICODE_O;
  logic [7:0]  INS_VALC_O;
  logic [13:0] INS_VALP_O;
  logic [1:0]  INS_LEN_O;
  logic [13:0] INS_PC_O;
  logic [13:0] INS_NPC_O;

  modport master (
    output I_ADDR_O,
    input  I_DAT_I,
    input  REDIR_I,
    input  REDIR_ADDR_I,
    output INS_VALID_O,
    input  INS_READY_I,
    output INS_ICODE_O,
    output INS_VALC_O,
    output INS_VALP_O,
    output INS_LEN_O,
    output INS_PC_O,
    output INS_NPC_O
  );

  modport slave (
    input  I_ADDR_O,
    output I_DAT_I,
    output REDIR_I,
    output REDIR_ADDR_I,
    input  INS_VALID_O,
    output INS_READY_I,
    input  INS_ICODE_O,
    input  INS_VALC_O,
    input  INS_VALP_O,
    input  INS_LEN_O,
    input  INS_PC_O,
    input  INS_NPC_O
  );
endinterface

// File: rtl/cpu_fetch.sv
// cpu_fetch -- byte-serial instruction fetch with a small byte queue.
// Fetches one ROM byte per cycle while there is room, queues the bytes with
// their addresses, and presents a whole 1/2/3-byte instruction to decode
// once enough bytes are queued.
// Ports:
//   CLK_I  : clock, all state changes on the rising edge
//   nRST_I : asynchronous active-low reset
//   bus    : cpu_fetch_if master (ROM port, redirect, decode handshake)
// Parameter:
//   QDEPTH : byte-queue depth, power of two, >= 4
module cpu_fetch #(
  parameter int QDEPTH = 4
) (
  input  logic        CLK_I,
  input  logic        nRST_I,
  cpu_fetch_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [13:0]   r_fpc;       // next address to fetch
  logic [13:0]   r_iaddr;     // last issued address, held on the ROM port
  logic          r_inflight;  // a byte answering r_iaddr arrives this cycle
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [7:0]    r_qdat  [QDEPTH];
  logic [13:0]   r_qaddr [QDEPTH];

  logic          w_room;
  logic          w_issue;
  logic [13:0]   w_src_pc;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [1:0]    w_len;
  logic [PW-1:0] w_h1;
  logic [PW-1:0] w_h2;
  logic [7:0]    w_op;
  logic [7:0]    w_b1;
  logic [5:0]    w_b2;
  logic [13:0]   w_pc;

  // Credit counts the in-flight byte too, so the queue can never overflow
  // even though the byte lands one cycle after its address is issued.
  assign w_room   = (r_count + CW'(r_inflight)) < CW'(QDEPTH);
  // A redirect flushes everything, so the target is always issued at once.
  assign w_issue  = bus.REDIR_I | w_room;
  assign w_src_pc = bus.REDIR_I ? bus.REDIR_ADDR_I : r_fpc;
  assign w_push   = r_inflight & ~bus.REDIR_I;

  // Queue window for the head instruction; pointers wrap naturally.
  assign w_h1 = r_head + PW'(1);
  assign w_h2 = r_head + PW'(2);
  assign w_op = r_qdat[r_head];
  assign w_b1 = r_qdat[w_h1];
  assign w_b2 = r_qdat[w_h2][5:0];
  assign w_pc = r_qaddr[r_head];

  always_comb begin
    w_len = 2'd1;
    casez (w_op)
      8'b01??_???0: w_len = 2'd3;
      8'b00??_?1?0: w_len = 2'd2;
      default:      w_len = 2'd1;
    endcase
  end

  // Redirect masks valid so a same-cycle handshake is dropped.
  assign w_valid = ~bus.REDIR_I & (r_count >= CW'(w_len));
  assign w_pop   = w_valid & bus.INS_READY_I;

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      r_fpc      <= '0;
      r_iaddr    <= '0;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_iaddr <= w_src_pc;
        r_fpc   <= w_src_pc + 14'd1;
      end
      if (bus.REDIR_I) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        r_count <= r_count + CW'(w_push) - (w_pop ? CW'(w_len) : '0);
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_pop)  r_head <= r_head + PW'(w_len);
      end
    end
  end

  // Queue storage needs no reset: occupancy alone says what is live.
  always_ff @(posedge CLK_I) begin
    if (w_push) begin
      r_qdat[r_tail]  <= bus.I_DAT_I;
      r_qaddr[r_tail] <= r_iaddr;
    end
  end

  assign bus.I_ADDR_O    = r_iaddr;
  assign bus.INS_VALID_O = w_valid;
  assign bus.INS_ICODE_O = w_valid ? w_op : 8'h00;
  assign bus.INS_VALC_O  = (w_valid && w_len != 2'd1) ? w_b1 : 8'h00;
  assign bus.INS_VALP_O  = (w_valid && w_len == 2'd3) ? {w_b2, w_b1} : 14'h0000;
  assign bus.INS_LEN_O   = w_valid ? w_len : 2'd0;
  assign bus.INS_PC_O    = w_valid ? w_pc : 14'h0000;
  assign bus.INS_NPC_O   = w_valid ? (w_pc + {12'd0, w_len}) : 14'h0000;
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch -- directed scenarios plus randomized traffic for cpu_fetch.
// The reference model works at instruction level: it keeps the PC of the
// next instruction decode must see and decodes it straight from the ROM
// image, independent of how the fetch unit queues bytes.
module tb_cpu_fetch;
  localparam int QD = 4;

  logic CLK_I;
  logic nRST_I;
  cpu_fetch_if bus();

  logic [7:0]  rom [16384];
  int          n_cmp;
  int          n_err;
  logic [13:0] exp_pc;
  bit          held;
  bit          redir_prev;
  int          idle;
  logic [59:0] w_outs;

  cpu_fetch #(.QDEPTH(QD)) dut (
    .CLK_I (CLK_I),
    .nRST_I(nRST_I),
    .bus   (bus)
  );

  assign bus.I_DAT_I = rom[bus.I_ADDR_O];
  assign w_outs = {bus.INS_ICODE_O, bus.INS_VALC_O, bus.INS_VALP_O,
                   bus.INS_LEN_O, bus.INS_PC_O, bus.INS_NPC_O};

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Instruction expected at pc, packed like w_outs.
  function automatic logic [59:0] expect_ins(input logic [13:0] pc);
    logic [13:0] a1, a2;
    logic [7:0]  op, b1, b2;
    logic [1:0]  n;
    a1 = pc + 14'd1;
    a2 = pc + 14'd2;
    op = rom[pc];
    b1 = rom[a1];
    b2 = rom[a2];
    casez (op)
      8'b01??_???0: n = 2'd3;
      8'b00??_?1?0: n = 2'd2;
      default:      n = 2'd1;
    endcase
    return {op, (n != 2'd1) ? b1 : 8'h00, (n == 2'd3) ? {b2[5:0], b1} : 14'h0,
            n, pc, pc + {12'd0, n}};
  endfunction

  // Per-cycle compare against the model.
  always @(negedge CLK_I) begin
    logic [59:0] e;
    if (!nRST_I) begin
      chk("reset_valid", 64'(bus.INS_VALID_O), 64'd0);
      exp_pc = 14'h0; held = 0; redir_prev = 0; idle = 0;
    end else if (bus.REDIR_I) begin
      chk("redir_valid_low", 64'(bus.INS_VALID_O), 64'd0);
      chk("redir_outs_zero", 64'(w_outs), 64'd0);
      exp_pc = bus.REDIR_ADDR_I; held = 0; idle = 0; redir_prev = 1;
    end else begin
      if (held) chk("stall_hold_valid", 64'(bus.INS_VALID_O), 64'd1);
      if (redir_prev) chk("redir_too_early", 64'(bus.INS_VALID_O), 64'd0);
      redir_prev = 0;
      if (bus.INS_VALID_O) begin
        e = expect_ins(exp_pc);
        chk("ins_fields", 64'(w_outs), 64'(e));
        idle = 0;
        if (bus.INS_READY_I) begin
          $display("acc pc=%h icode=%h valc=%h valp=%h len=%0d npc=%h",
                   bus.INS_PC_O, bus.INS_ICODE_O, bus.INS_VALC_O,
                   bus.INS_VALP_O, bus.INS_LEN_O, bus.INS_NPC_O);
          exp_pc = exp_pc + {12'd0, e[29:28]};
          held = 0;
        end else begin
          held = 1;
        end
      end else begin
        chk("idle_outs_zero", 64'(w_outs), 64'd0);
        held = 0;
        idle++;
        if (idle > 8) begin
          chk("liveness_valid", 64'(bus.INS_VALID_O), 64'd1);
          idle = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    do begin
      @(negedge CLK_I);
      k++;
    end while (!bus.INS_VALID_O && k < 20);
    chk(name, 64'(bus.INS_VALID_O), 64'd1);
  endtask

  task automatic redirect(input logic [13:0] a);
    tick();
    bus.REDIR_I = 1'b1;
    bus.REDIR_ADDR_I = a;
  endtask

  initial begin
    int amax;
    bit rst_pulse;
    n_cmp = 0; n_err = 0;
    exp_pc = 14'h0; held = 0; redir_prev = 0; idle = 0;
    for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
    nRST_I = 1'b0;
    bus.INS_READY_I = 1'b1;
    bus.REDIR_I = 1'b0;
    bus.REDIR_ADDR_I = 14'h0;
    tick(); tick();
    @(negedge CLK_I);
    chk("rst_valid", 64'(bus.INS_VALID_O), 64'd0);
    chk("rst_addr", 64'(bus.I_ADDR_O), 64'd0);
    chk("rst_outs", 64'(w_outs), 64'd0);

    // Four 1-byte instructions back to back.
    rom[0] = 8'hC1; rom[1] = 8'hC2; rom[2] = 8'hC3; rom[3] = 8'hC4;
    tick();
    nRST_I = 1'b1;
    wait_valid("t1_first_valid");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge CLK_I);
      chk("t1_valid", 64'(bus.INS_VALID_O), 64'd1);
      chk("t1_icode", 64'(bus.INS_ICODE_O), 64'(8'hC1 + k));
      chk("t1_pc", 64'(bus.INS_PC_O), 64'(k));
      chk("t1_len", 64'(bus.INS_LEN_O), 64'd1);
    end

    // 2-byte then 3-byte instruction.
    tick();
    nRST_I = 1'b0;
    rom[0] = 8'h06; rom[1] = 8'h5A; rom[2] = 8'h44; rom[3] = 8'h34; rom[4] = 8'h12;
    tick();
    nRST_I = 1'b1;
    wait_valid("t2_valid_a");
    chk("t2_icode_a", 64'(bus.INS_ICODE_O), 64'h06);
    chk("t2_valc_a", 64'(bus.INS_VALC_O), 64'h5A);
    chk("t2_len_a", 64'(bus.INS_LEN_O), 64'd2);
    chk("t2_npc_a", 64'(bus.INS_NPC_O), 64'h0002);
    wait_valid("t2_valid_b");
    chk("t2_icode_b", 64'(bus.INS_ICODE_O), 64'h44);
    chk("t2_len_b", 64'(bus.INS_LEN_O), 64'd3);
    chk("t2_valp_b", 64'(bus.INS_VALP_O), 64'h1234);
    chk("t2_npc_b", 64'(bus.INS_NPC_O), 64'h0005);

    // Redirect to 0010, 3-byte instruction, latency lower bound.
    redirect(14'h0010);
    rom[16] = 8'h44; rom[17] = 8'h34; rom[18] = 8'h12;
    tick();
    bus.REDIR_I = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK_I);
      chk("t3_not_early", 64'(bus.INS_VALID_O), 64'd0);
    end
    wait_valid("t3_valid");
    chk("t3_icode", 64'(bus.INS_ICODE_O), 64'h44);
    chk("t3_valp", 64'(bus.INS_VALP_O), 64'h1234);
    chk("t3_len", 64'(bus.INS_LEN_O), 64'd3);
    chk("t3_npc", 64'(bus.INS_NPC_O), 64'h0013);

    // Decode stalled after reset: issue stops at QD bytes.
    tick();
    nRST_I = 1'b0;
    bus.INS_READY_I = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
    tick();
    nRST_I = 1'b1;
    amax = 0;
    repeat (10) begin
      @(negedge CLK_I);
      if (int'(bus.I_ADDR_O) > amax) amax = int'(bus.I_ADDR_O);
    end
    chk("t4_addr_max", 64'(amax), 64'(QD - 1));
    chk("t4_addr_hold", 64'(bus.I_ADDR_O), 64'(QD - 1));
    chk("t4_valid", 64'(bus.INS_VALID_O), 64'd1);
    chk("t4_icode", 64'(bus.INS_ICODE_O), 64'(rom[0]));
    tick();
    bus.INS_READY_I = 1'b1;
    repeat (12) @(negedge CLK_I);

    // Steady 1-byte stream, then redirect over a live handshake.
    redirect(14'h0100);
    for (int i = 0; i < 32; i++) rom[14'h0100 + i] = 8'hC0;
    tick();
    bus.REDIR_I = 1'b0;
    @(negedge CLK_I);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK_I);
      chk("t5_stream", 64'(bus.INS_VALID_O), 64'd1);
    end
    redirect(14'h2000);
    tick();
    bus.REDIR_I = 1'b0;
    wait_valid("t5_valid");
    chk("t5_pc", 64'(bus.INS_PC_O), 64'h2000);

    // Instruction wrapping 3FFF -> 0000, then async reset mid-run.
    redirect(14'h3FFF);
    rom[16383] = 8'h44; rom[0] = 8'hCD; rom[1] = 8'h2B;
    tick();
    bus.REDIR_I = 1'b0;
    wait_valid("t6_valid");
    chk("t6_icode", 64'(bus.INS_ICODE_O), 64'h44);
    chk("t6_valp", 64'(bus.INS_VALP_O), 64'h2BCD);
    chk("t6_npc", 64'(bus.INS_NPC_O), 64'h0002);
    chk("t6_pc", 64'(bus.INS_PC_O), 64'h3FFF);
    repeat (3) tick();
    @(posedge CLK_I);
    #3;
    nRST_I = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.INS_VALID_O), 64'd0);
    chk("t6_rst_outs", 64'(w_outs), 64'd0);
    chk("t6_rst_addr", 64'(bus.I_ADDR_O), 64'd0);
    tick();
    nRST_I = 1'b1;

    // Randomized traffic.
    rst_pulse = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      nRST_I = 1'b1;
      bus.REDIR_I = 1'b0;
      if (rst_pulse) begin
        rst_pulse = 0;
      end else if ($urandom_range(0, 499) == 0) begin
        nRST_I = 1'b0;
        rst_pulse = 1;
      end else if ($urandom_range(0, 99) < 3) begin
        bus.REDIR_I = 1'b1;
        if ($urandom_range(0, 3) == 0)
          bus.REDIR_ADDR_I = 14'h3FFC + 14'($urandom_range(0, 3));
        else
          bus.REDIR_ADDR_I = 14'($urandom);
      end
      if ((cyc % 256) < 10) bus.INS_READY_I = 1'b0;
      else bus.INS_READY_I = ($urandom_range(0, 9) < 7);
    end
    tick();
    bus.REDIR_I = 1'b0;
    nRST_I = 1'b1;
    bus.INS_READY_I = 1'b1;
    repeat (10) @(negedge CLK_I);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
